baccarat_datapath: RTL and testbench

BACCARAT_DATAPATH -- requirements
Module: baccarat_datapath

---
 rtl/baccarat_datapath_if.sv | 33 +++
 rtl/baccarat_datapath.sv | 91 +++++++++
 tb/tb_baccarat_datapath.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/baccarat_datapath_if.sv
// Baccarat datapath bus: load strobes from the controller, card/score/status back.
interface baccarat_datapath_if;
  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;
  logic [3:0] pcard1;
  logic [3:0] pcard2;
  logic [3:0] pcard3;
  logic [3:0] dcard1;
  logic [3:0] dcard2;
  logic [3:0] dcard3;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [2:0] cards_dealt;
  logic       load_error;

  modport master (
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    input  pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
    input  pscore, dscore, cards_dealt, load_error
  );

  modport slave (
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    output pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
    output pscore, dscore, cards_dealt, load_error
  );
endinterface

// File: rtl/baccarat_datapath.sv
// Baccarat datapath: free-running deck counter, six card slots loaded by
// one-hot strobes, combinational mod-10 hand scores, deal count and a
// sticky error for cycles with more than one strobe.
module baccarat_datapath #(
  parameter logic [3:0] FIRST_CARD = 4'd1
) (
  input logic                 slow_clock,
  input logic                 reset,
  baccarat_datapath_if.slave  bus
);

  logic [3:0] deck;
  logic [5:0] strobes;
  logic       single_load;
  logic       multi_load;
  logic [3:0] card_q [6];
  logic [2:0] dealt_q;
  logic       error_q;

  // Slot order: player 1..3 in bits 0..2, dealer 1..3 in bits 3..5.
  assign strobes = {bus.load_dcard3, bus.load_dcard2, bus.load_dcard1,
                    bus.load_pcard3, bus.load_pcard2, bus.load_pcard1};

  // Clearing the lowest set bit leaves something only when two or more are set.
  assign multi_load  = (strobes & (strobes - 6'd1)) != 6'd0;
  assign single_load = (strobes != 6'd0) && !multi_load;

  function automatic logic [3:0] card_value(input logic [3:0] c);
    return (c <= 4'd9) ? c : 4'd0;
  endfunction

  // Sum of three values is at most 27, so two conditional subtracts give mod 10.
  function automatic logic [3:0] hand_score(input logic [3:0] a,
                                            input logic [3:0] b,
                                            input logic [3:0] c);
    logic [4:0] sum;
    sum = {1'b0, card_value(a)} + {1'b0, card_value(b)} + {1'b0, card_value(c)};
    if (sum >= 5'd20)
      sum = sum - 5'd20;
    else if (sum >= 5'd10)
      sum = sum - 5'd10;
    return 4'(sum);
  endfunction

  // Deck advances every edge 1..13 and wraps; any out-of-range value recovers to 1.
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset)
      deck <= FIRST_CARD;
    else if (deck >= 4'd1 && deck <= 4'd12)
      deck <= deck + 4'd1;
    else
      deck <= 4'd1;
  end

  // A legal single strobe captures the pre-increment deck into its slot.
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 6; i++)
        card_q[i] <= 4'd0;
    end else if (single_load) begin
      for (int i = 0; i < 6; i++)
        if (strobes[i])
          card_q[i] <= deck;
    end
  end

  // Deal count saturates at 6; the error flag is sticky until reset.
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      dealt_q <= 3'd0;
      error_q <= 1'b0;
    end else begin
      if (single_load && dealt_q != 3'd6)
        dealt_q <= dealt_q + 3'd1;
      if (multi_load)
        error_q <= 1'b1;
    end
  end

  assign bus.pcard1      = card_q[0];
  assign bus.pcard2      = card_q[1];
  assign bus.pcard3      = card_q[2];
  assign bus.dcard1      = card_q[3];
  assign bus.dcard2      = card_q[4];
  assign bus.dcard3      = card_q[5];
  assign bus.pscore      = hand_score(card_q[0], card_q[1], card_q[2]);
  assign bus.dscore      = hand_score(card_q[3], card_q[4], card_q[5]);
  assign bus.cards_dealt = dealt_q;
  assign bus.load_error  = error_q;

endmodule

// File: tb/tb_baccarat_datapath.sv
// Bench for baccarat_datapath: directed deals checked every cycle against a
// behavioural model, plus literal expectations for the documented scenarios.
module tb_baccarat_datapath;

  localparam logic [3:0] FIRST_CARD = 4'd1;

  localparam logic [5:0] P1 = 6'b000001;
  localparam logic [5:0] P2 = 6'b000010;
  localparam logic [5:0] P3 = 6'b000100;
  localparam logic [5:0] D1 = 6'b001000;
  localparam logic [5:0] D2 = 6'b010000;
  localparam logic [5:0] D3 = 6'b100000;

  logic slow_clock;
  logic reset;
  baccarat_datapath_if bus ();

  baccarat_datapath #(.FIRST_CARD(FIRST_CARD)) dut (
    .slow_clock (slow_clock),
    .reset      (reset),
    .bus        (bus)
  );

  initial slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state.
  int m_deck;
  int m_card [6];
  int m_dealt;
  int m_err;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_score(input int a, input int b, input int c);
    int s;
    s = 0;
    if (a >= 1 && a <= 9) s += a;
    if (b >= 1 && b <= 9) s += b;
    if (c >= 1 && c <= 9) s += c;
    return s % 10;
  endfunction

  task automatic model_reset();
    m_deck  = FIRST_CARD;
    m_dealt = 0;
    m_err   = 0;
    for (int i = 0; i < 6; i++) m_card[i] = 0;
  endtask

  task automatic model_edge(input logic [5:0] s);
    int n;
    int idx;
    n = 0;
    idx = 0;
    for (int i = 0; i < 6; i++)
      if (s[i]) begin
        n++;
        idx = i;
      end
    if (n == 1) begin
      m_card[idx] = m_deck;
      if (m_dealt < 6) m_dealt++;
    end else if (n > 1) begin
      m_err = 1;
    end
    m_deck = (m_deck >= 13 || m_deck < 1) ? 1 : m_deck + 1;
  endtask

  task automatic drive(input logic [5:0] s);
    bus.load_pcard1 = s[0];
    bus.load_pcard2 = s[1];
    bus.load_pcard3 = s[2];
    bus.load_dcard1 = s[3];
    bus.load_dcard2 = s[4];
    bus.load_dcard3 = s[5];
  endtask

  task automatic step(input logic [5:0] s);
    drive(s);
    @(posedge slow_clock);
    model_edge(s);
    #1 drive(6'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(6'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pcard1"}, bus.pcard1, 0);
    check({tag, "_pcard2"}, bus.pcard2, 0);
    check({tag, "_pcard3"}, bus.pcard3, 0);
    check({tag, "_dcard1"}, bus.dcard1, 0);
    check({tag, "_dcard2"}, bus.dcard2, 0);
    check({tag, "_dcard3"}, bus.dcard3, 0);
    check({tag, "_pscore"}, bus.pscore, 0);
    check({tag, "_dscore"}, bus.dscore, 0);
    check({tag, "_dealt"},  bus.cards_dealt, 0);
    check({tag, "_err"},    bus.load_error, 0);
  endtask

  // Assert reset between edges, confirm outputs clear before any edge, hold it
  // across an edge with every strobe high, then release away from the edge.
  task automatic apply_reset(input string tag);
    @(negedge slow_clock);
    #2 reset = 1'b1;
    #1 model_reset();
    check_all_zero(tag);
    drive(6'b111111);
    @(posedge slow_clock);
    @(negedge slow_clock);
    #2 reset = 1'b0;
    drive(6'b0);
  endtask

  // Every cycle, away from the active edge, compare all outputs to the model.
  always @(negedge slow_clock) begin
    if (cmp_en) begin
      check("m_pcard1", bus.pcard1, m_card[0]);
      check("m_pcard2", bus.pcard2, m_card[1]);
      check("m_pcard3", bus.pcard3, m_card[2]);
      check("m_dcard1", bus.dcard1, m_card[3]);
      check("m_dcard2", bus.dcard2, m_card[4]);
      check("m_dcard3", bus.dcard3, m_card[5]);
      check("m_pscore", bus.pscore, model_score(m_card[0], m_card[1], m_card[2]));
      check("m_dscore", bus.dscore, model_score(m_card[3], m_card[4], m_card[5]));
      check("m_dealt",  bus.cards_dealt, m_dealt);
      check("m_err",    bus.load_error, m_err);
    end
  end

  initial begin
    reset = 1'b0;
    drive(6'b0);
    model_reset();
    #1 reset = 1'b1;
    #1 cmp_en = 1'b1;
    check_all_zero("por");
    @(posedge slow_clock);
    @(negedge slow_clock);
    #2 reset = 1'b0;

    // Normal deal.
    step(P1); step(D1); step(P2); step(D2);
    check("deal_pcard1", bus.pcard1, 1);
    check("deal_dcard1", bus.dcard1, 2);
    check("deal_pcard2", bus.pcard2, 3);
    check("deal_dcard2", bus.dcard2, 4);
    check("deal_pscore", bus.pscore, 4);
    check("deal_dscore", bus.dscore, 6);
    check("deal_dealt",  bus.cards_dealt, 4);
    step(P3);
    check("deal_pcard3", bus.pcard3, 5);
    check("deal_pscore3", bus.pscore, 9);
    check("deal_dealt5", bus.cards_dealt, 5);

    // Async reset mid-hand, then first load after release.
    apply_reset("midhand");
    step(P1);
    check("rst_pcard1", bus.pcard1, 1);

    // Face card worth zero.
    apply_reset("face");
    idle(9);
    step(P1);
    check("face_pcard1", bus.pcard1, 10);
    check("face_pscore", bus.pscore, 0);

    // Mod-10 wrap.
    apply_reset("mod");
    idle(7);
    step(P1); step(P2);
    check("mod_pcard1", bus.pcard1, 8);
    check("mod_pcard2", bus.pcard2, 9);
    check("mod_pscore", bus.pscore, 7);

    // Deck wrap 13 -> 1.
    apply_reset("wrap");
    idle(12);
    step(D1); step(D2);
    check("wrap_dcard1", bus.dcard1, 13);
    check("wrap_dcard2", bus.dcard2, 1);
    check("wrap_dscore", bus.dscore, 1);

    // Illegal double strobe.
    apply_reset("ill");
    step(P1 | D1);
    check("ill_pcard1", bus.pcard1, 0);
    check("ill_dcard1", bus.dcard1, 0);
    check("ill_err",    bus.load_error, 1);
    check("ill_dealt",  bus.cards_dealt, 0);
    step(P1);
    check("ill_next_pcard1", bus.pcard1, 2);
    check("ill_next_err",    bus.load_error, 1);
    step(P3 | D2 | D3);
    check("ill_triple_pcard3", bus.pcard3, 0);
    check("ill_triple_dealt",  bus.cards_dealt, 1);

    // Saturation and overwrite.
    apply_reset("sat");
    step(P1); step(P2); step(P3); step(D1); step(D2); step(D3);
    check("sat_dealt6", bus.cards_dealt, 6);
    check("sat_pscore", bus.pscore, 6);
    check("sat_dscore", bus.dscore, 5);
    step(P1);
    check("sat_dealt7", bus.cards_dealt, 6);
    check("sat_overwrite", bus.pcard1, 7);
    check("sat_pscore7", bus.pscore, 2);
    check("sat_err", bus.load_error, 0);

    // Longer run: repeated overwrites across several deck wraps.
    for (int i = 0; i < 30; i++) begin
      step(6'b1 << (i % 6));
      if (i % 4 == 3) idle(i % 5);
    end
    step(6'b0);

    @(negedge slow_clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
